// File: rtl/daq_dma_writer.sv
// daq_dma_writer: buffers DAQ words in a FIFO and writes them to memory; a word reaches mem_write 3 cycles after daq_write.
// mem_waitrequest stalls the engine, a full FIFO drops words (overflow); define DAQ_WRAP_EN for ring-buffer addressing.
module daq_dma_writer #(
  parameter int FIFO_AW = 9,
  parameter int MEM_AW  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              daq_write,
  input  logic [15:0]       daq_writedata,
  output logic              daq_running,
  input  logic [1:0]        ctrl_address,
  input  logic              ctrl_write,
  input  logic [31:0]       ctrl_writedata,
  input  logic              ctrl_read,
  output logic [31:0]       ctrl_readdata,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  input  logic              mem_waitrequest
);
  localparam int DEPTH = 2**FIFO_AW;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic [31:0]         base_q, base_d;
  logic [31:0]         size_q, size_d;
  logic [31:0]         ptr_q, ptr_d;
  logic                overflow_q, overflow_d;
  logic                mem_full_q, mem_full_d;
  logic                wrapped_q, wrapped_d;
  logic                daq_running_q, daq_running_d;
  logic                mem_write_q, mem_write_d;
  logic [MEM_AW-1:0]   mem_address_q, mem_address_d;
  logic [15:0]         mem_writedata_q, mem_writedata_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic [15:0]         fifo_mem [DEPTH];

  logic fifo_empty, fifo_full, reg_wr2, run_rise;
  logic accept, at_end, pop, push, flush;
  logic unused_ctrl_read;

  assign unused_ctrl_read = ctrl_read;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
    reg_wr2    = ctrl_write && (ctrl_address == 2'd2);
    run_rise   = reg_wr2 && ctrl_writedata[0] && !run_q;
    accept     = (state_q == WRITE) && !mem_waitrequest;
    at_end     = accept && ((ptr_q + 32'd1) == size_q);
    pop        = (state_q == FETCH) && !run_rise;
`ifdef DAQ_WRAP_EN
    flush      = run_rise;
`else
    flush      = run_rise || at_end;
`endif
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = daq_write && daq_running_q && (!fifo_full || pop) && !flush;

    run_d  = run_q;
    base_d = base_q;
    size_d = size_q;
    if (ctrl_write) begin
      case (ctrl_address)
        2'd0:    if (!run_q) base_d = {ctrl_writedata[31:1], 1'b0};
        2'd1:    if (!run_q) size_d = ctrl_writedata;
        2'd2:    run_d = ctrl_writedata[0];
        default: ;
      endcase
    end

    overflow_d = overflow_q;
    mem_full_d = mem_full_q;
    wrapped_d  = wrapped_q;
    if (reg_wr2 && ctrl_writedata[1]) begin
      overflow_d = 1'b0;
      mem_full_d = 1'b0;
      wrapped_d  = 1'b0;
    end
    if (daq_write && daq_running_q && fifo_full && !pop) overflow_d = 1'b1;

    state_d         = state_q;
    ptr_d           = ptr_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    case (state_q)
      IDLE: if (!fifo_empty && !mem_full_q) state_d = FETCH;
      FETCH: begin
        state_d         = WRITE;
        mem_address_d   = MEM_AW'(base_q + {ptr_q[30:0], 1'b0});
        mem_writedata_d = fifo_mem[rd_ptr_q];
      end
      WRITE: begin
        if (accept) begin
          ptr_d   = ptr_q + 32'd1;
          state_d = fifo_empty ? IDLE : FETCH;
          if (at_end) begin
`ifdef DAQ_WRAP_EN
            ptr_d     = '0;
            wrapped_d = 1'b1;
`else
            mem_full_d = 1'b1;
            state_d    = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Re-arming restarts the region from scratch and abandons any queued data.
    if (run_rise) begin
      ptr_d      = '0;
      overflow_d = 1'b0;
      mem_full_d = 1'b0;
      wrapped_d  = 1'b0;
      state_d    = IDLE;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end

    daq_running_d = run_d && !mem_full_d && (size_d != 32'd0);
    mem_write_d   = (state_d == WRITE);

    case (ctrl_address)
      2'd0:    ctrl_readdata = base_q;
      2'd1:    ctrl_readdata = size_q;
      2'd2:    ctrl_readdata = {16'(count_q), 11'd0, fifo_empty, wrapped_q,
                                mem_full_q, overflow_q, run_q};
      default: ctrl_readdata = ptr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= daq_writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      run_q           <= 1'b0;
      base_q          <= '0;
      size_q          <= '0;
      ptr_q           <= '0;
      overflow_q      <= 1'b0;
      mem_full_q      <= 1'b0;
      wrapped_q       <= 1'b0;
      daq_running_q   <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      base_q          <= base_d;
      size_q          <= size_d;
      ptr_q           <= ptr_d;
      overflow_q      <= overflow_d;
      mem_full_q      <= mem_full_d;
      wrapped_q       <= wrapped_d;
      daq_running_q   <= daq_running_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign daq_running   = daq_running_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
endmodule

// File: tb/tb_daq_dma_writer.sv
// Directed bench for daq_dma_writer with a 4-deep FIFO; accepted memory writes are logged and compared to hand-computed lists.
module tb_daq_dma_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic        daq_write;
  logic [15:0] daq_writedata;
  logic        daq_running;
  logic [1:0]  ctrl_address;
  logic        ctrl_write;
  logic [31:0] ctrl_writedata;
  logic        ctrl_read;
  logic [31:0] ctrl_readdata;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest;

  int n_checks = 0;
  int n_pass   = 0;
  int k;
  int bad;
  logic [31:0] got_addr[$];
  logic [15:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [15:0] exp_data[$];

  daq_dma_writer #(.FIFO_AW(2), .MEM_AW(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .daq_write       (daq_write),
    .daq_writedata   (daq_writedata),
    .daq_running     (daq_running),
    .ctrl_address    (ctrl_address),
    .ctrl_write      (ctrl_write),
    .ctrl_writedata  (ctrl_writedata),
    .ctrl_read       (ctrl_read),
    .ctrl_readdata   (ctrl_readdata),
    .mem_address     (mem_address),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write && !mem_waitrequest) begin
      got_addr.push_back(mem_address);
      got_data.push_back(mem_writedata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
    ctrl_address   = a;
    ctrl_writedata = d;
    ctrl_write     = 1'b1;
    @(posedge clk); #1;
    ctrl_write     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    ctrl_address = a;
    ctrl_read    = 1'b1;
    #1;
    chk(tag, ctrl_readdata, exp);
    ctrl_read    = 1'b0;
  endtask

  task automatic push_seq(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      daq_writedata = first + 16'(i);
      daq_write     = 1'b1;
      @(posedge clk); #1;
    end
    daq_write = 1'b0;
  endtask

  task automatic start(input logic [31:0] b, input logic [31:0] s);
    ctrl_wr(2'd2, 32'd0);
    ctrl_wr(2'd0, b);
    ctrl_wr(2'd1, s);
    ctrl_wr(2'd2, 32'd1);
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [15:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), {16'd0, got_data[i]}, {16'd0, exp_data[i]});
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    daq_write = 1'b0;
    daq_writedata = '0;
    ctrl_address = '0;
    ctrl_write = 1'b0;
    ctrl_writedata = '0;
    ctrl_read = 1'b0;
    mem_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_running", daq_running, 1'b0);
    chk("rst_mem_addr", mem_address, 32'h0);
    rd_chk("rst_base", 2'd0, 32'h0);
    rd_chk("rst_size", 2'd1, 32'h0);
    rd_chk("rst_status", 2'd2, 32'h10);
    rd_chk("rst_ptr", 2'd3, 32'h0);

    // Four words fill a four-word region exactly
    start(32'h1000, 32'd4);
    chk("a_running", daq_running, 1'b1);
    push_seq(16'hA001, 4);
    wait_cycles(15);
    expect_wr(32'h1000, 16'hA001);
    expect_wr(32'h1002, 16'hA002);
    expect_wr(32'h1004, 16'hA003);
    expect_wr(32'h1006, 16'hA004);
    check_writes("a");
    rd_chk("a_ptr", 2'd3, 32'd4);
    rd_chk("a_status", 2'd2, 32'h15);
    chk("a_running_end", daq_running, 1'b0);

    // Latency and stall behaviour under waitrequest
    mem_waitrequest = 1'b1;
    start(32'h2001, 32'd8);
    rd_chk("b_base_bit0", 2'd0, 32'h2000);
    push_seq(16'hB001, 1);
    wait_cycles(1);
    chk("b_lat_n2", mem_write, 1'b0);
    wait_cycles(1);
    chk("b_lat_n3", mem_write, 1'b1);
    chk("b_addr", mem_address, 32'h2000);
    chk("b_data", mem_writedata, 16'hB001);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      wait_cycles(1);
      if (mem_write !== 1'b1 || mem_address !== 32'h2000 || mem_writedata !== 16'hB001) bad++;
    end
    chk("b_stable", bad, 0);
    rd_chk("b_ptr_stall", 2'd3, 32'd0);
    mem_waitrequest = 1'b0;
    wait_cycles(1);
    chk("b_mw_after", mem_write, 1'b0);
    rd_chk("b_ptr", 2'd3, 32'd1);
    expect_wr(32'h2000, 16'hB001);
    check_writes("b");

    // Overflow: one word held in WRITE, four queued, the sixth dropped
    mem_waitrequest = 1'b1;
    start(32'h3000, 32'd16);
    push_seq(16'hC001, 6);
    rd_chk("c_status_ovf", 2'd2, 32'h0004_0003);
    chk("c_held_data", mem_writedata, 16'hC001);
    ctrl_wr(2'd2, 32'd3);
    rd_chk("c_status_clr", 2'd2, 32'h0004_0001);
    ctrl_wr(2'd1, 32'd99);
    rd_chk("c_size_locked", 2'd1, 32'd16);
    mem_waitrequest = 1'b0;
    wait_cycles(20);
    for (int i = 0; i < 5; i++) expect_wr(32'h3000 + 32'(2*i), 16'hC001 + 16'(i));
    check_writes("c");
    rd_chk("c_ptr", 2'd3, 32'd5);

    // Region end discards the remaining words
    start(32'h4000, 32'd3);
    push_seq(16'hD001, 5);
    wait_cycles(15);
    for (int i = 0; i < 3; i++) expect_wr(32'h4000 + 32'(2*i), 16'hD001 + 16'(i));
    check_writes("d");
    rd_chk("d_status", 2'd2, 32'h15);
    rd_chk("d_ptr", 2'd3, 32'd3);
    ctrl_wr(2'd2, 32'd0);
    chk("d_stop_running", daq_running, 1'b0);
    push_seq(16'hDEAD, 1);
    rd_chk("d_ignored", 2'd2, 32'h14);
    ctrl_wr(2'd2, 32'd1);
    rd_chk("d_restart_status", 2'd2, 32'h11);
    rd_chk("d_restart_ptr", 2'd3, 32'd0);
    chk("d_restart_running", daq_running, 1'b1);

    // Two-word region with three words
    start(32'h5000, 32'd2);
    push_seq(16'h0001, 3);
    wait_cycles(15);
    expect_wr(32'h5000, 16'h0001);
    expect_wr(32'h5002, 16'h0002);
`ifdef DAQ_WRAP_EN
    expect_wr(32'h5000, 16'h0003);
    check_writes("e");
    rd_chk("e_ptr", 2'd3, 32'd1);
    rd_chk("e_status", 2'd2, 32'h19);
    chk("e_running", daq_running, 1'b1);
`else
    check_writes("e");
    rd_chk("e_ptr", 2'd3, 32'd2);
    rd_chk("e_status", 2'd2, 32'h15);
    chk("e_running", daq_running, 1'b0);
`endif

    // Asynchronous reset during a stalled write
    mem_waitrequest = 1'b1;
    start(32'h6000, 32'd8);
    push_seq(16'hF001, 1);
    k = 0;
    while (mem_write !== 1'b1 && k < 10) begin
      wait_cycles(1);
      k++;
    end
    chk("f_mw_before", mem_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("f_mw_reset", mem_write, 1'b0);
    chk("f_running_reset", daq_running, 1'b0);
    rd_chk("f_base", 2'd0, 32'h0);
    rd_chk("f_size", 2'd1, 32'h0);
    rd_chk("f_status", 2'd2, 32'h10);
    rd_chk("f_ptr", 2'd3, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    mem_waitrequest = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/daq_dma_writer.md
Name: daq_dma_writer

Overview:
Consumer end of one DAQ output channel: accepts the 16-bit word stream produced by the DAQ front end (write strobe plus writedata) and stores it in SDRAM through an Avalon-MM write master. It buffers bursts in an internal FIFO, drives the channel's running flag back to the producer, and reports fill/overflow status over an Avalon control slave. One instance serves each daqN / daqNa / daqNb channel.

Parameters:
FIFO_AW, 9, FIFO address width; depth = 2**FIFO_AW words
MEM_AW, 32, byte-address width of the memory master

Ports:
clk  in  1  system/DAQ clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
daq_write  in  1  word strobe from producer, one word per high cycle
daq_writedata  in  16  data word, valid with daq_write
daq_running  out  1  channel armed and not stopped by memory limit
ctrl_address  in  2  control register select
ctrl_write  in  1  control write strobe
ctrl_writedata  in  32  control write data
ctrl_read  in  1  control read strobe
ctrl_readdata  out  32  control read data, combinational from ctrl_address
mem_address  out  MEM_AW  byte address of current memory write
mem_write  out  1  memory write request
mem_writedata  out  16  memory write data
mem_waitrequest  in  1  Avalon stall; request held while high

Behaviour:
- Registers: 0 base (byte addr, bit0 ignored), 1 size (words), 2 ctrl/status, 3 ptr (words committed, read-only).
- Reg 2 write: bit0 run, bit1=1 clears sticky flags. Reg 2 read: bit0 run, bit1 overflow, bit2 mem_full, bit3 wrapped, bit4 fifo_empty, bits[31:16] FIFO level.
- Reset: run=0, base=0, size=0, ptr=0, flags=0, FIFO empty, daq_running=0, mem_write=0, mem_address=0, mem_writedata=0.
- Run 0->1 (rising on write of bit0): ptr=0, all flags cleared, FIFO flushed, same cycle; daq_running high next cycle if size!=0.
- daq_running = run & !mem_full & (size!=0), registered.
- Ingest: daq_write & daq_running & FIFO not full -> push. daq_write while FIFO full -> word dropped, overflow set (sticky). daq_write while !daq_running -> ignored, no flag.
- Simultaneous push and pop on a full FIFO: pop wins slot, push accepted.
- Write engine FSM: IDLE -> FETCH when FIFO not empty and !mem_full; FETCH (1-cycle FIFO read latency) -> WRITE; WRITE asserts mem_write with mem_address = base + 2*ptr, mem_writedata = word; holds all three stable while mem_waitrequest=1; on accept ptr+1 and -> FETCH if FIFO not empty else IDLE.
- Latency: word in on cycle N, earliest mem_write on N+3 with empty FIFO, idle engine.
- Memory end (ptr+1 == size on accept): mem_full set, daq_running falls next cycle, remaining FIFO contents flushed, FSM -> IDLE.
- Run 1->0: daq_running low next cycle; FIFO drains normally to memory, then IDLE. ptr stays readable.
- Writes to base/size while run=1 ignored.
- Reset mid-transfer: mem_write drops immediately (async), FIFO contents lost.

Optional Feature:
DAQ_WRAP_EN: when defined, memory is a ring buffer: on ptr+1 == size accept, ptr wraps to 0, wrapped flag (bit3) set sticky, mem_full never set, daq_running stays high. When undefined, stop-at-end behaviour above; bit3 reads 0.

Test Plan:
- base=0x1000, size=4, run=1, push 0xA001..0xA004 on consecutive cycles, waitrequest=0 -> writes to 0x1000,0x1002,0x1004,0x1006 in order, ptr=4, mem_full=1, daq_running=0.
- waitrequest held high 10 cycles during first write -> mem_address/data stable throughout, no word lost, ptr increments once on release.
- FIFO_AW=2, waitrequest=1, push 6 words -> first 4 stored (one held in WRITE, pops allow one more), extra dropped, overflow=1; write reg2 bit1=1 -> overflow=0.
- size=3, push 5 words -> 3 written, 2 discarded, status bit2=1; rising run restart -> ptr=0, flags clear, FIFO empty.
- DAQ_WRAP_EN, size=2, push 0x0001..0x0003 -> third word at base+0, wrapped=1, daq_running remains 1.
- assert reset while mem_write=1 -> mem_write=0 and daq_running=0 same cycle, all registers read 0.
